// File: rtl/fifo_ddr3_pkg.sv
// Shared types and helpers for the DDR3 write-strobe FIFO read path.
package fifo_ddr3_pkg;

  localparam int DDR3_DATA_W = 128;
  localparam int DDR3_STRB_W = 16;

  typedef struct packed {
    logic [DDR3_DATA_W-1:0] data;
    logic [DDR3_STRB_W-1:0] strb;
  } wr_word_t;

  // Index width for a buffer of the given depth, never less than one bit.
  function automatic int clog2_depth(input int depth);
    int w;
    w = 1;
    while ((32'sd1 <<< w) < depth) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_ddr3_skid_buf.sv
// Circular skid buffer with occupancy counter; depth need not be a power of two.
module fifo_ddr3_skid_buf
  import fifo_ddr3_pkg::*;
#(
  parameter int DATA_WIDTH = $bits(wr_word_t),
  parameter int BUF_DEPTH  = 3,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [CNT_WIDTH-1:0]  occ,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int               PTR_W    = clog2_depth(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_r [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_WIDTH-1:0]  occ_r;
  logic                  pop_s;

  // A pop is only honoured when a word is actually held.
  always_comb begin
    pop_s = pop && (occ_r != {CNT_WIDTH{1'b0}});
  end

  // Pointer wrap by explicit compare and occupancy bookkeeping.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {CNT_WIDTH{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop_s})
        2'b10:   occ_r <= occ_r + CNT_WIDTH'(1);
        2'b01:   occ_r <= occ_r - CNT_WIDTH'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Word storage; contents are don't-care after reset.
  always_ff @(posedge rclk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign occ  = occ_r;
  assign head = mem_r[rd_ptr_r];

  fifo_ddr3_skid_buf_chk #(
    .BUF_DEPTH(BUF_DEPTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_chk (
    .rclk(rclk),
    .rrst(rrst),
    .occ (occ_r)
  );

endmodule

// File: rtl/fifo_ddr3_skid_buf_chk.sv
// Property checker for the FWFT skid buffer occupancy.
module fifo_ddr3_skid_buf_chk #(
  parameter int BUF_DEPTH = 3,
  parameter int CNT_WIDTH = 3
) (
  input logic                 rclk,
  input logic                 rrst,
  input logic [CNT_WIDTH-1:0] occ
);

  // Credit accounting must keep occupancy within the buffer.
  a_occ_bound: assert property (@(posedge rclk) disable iff (rrst) occ <= CNT_WIDTH'(BUF_DEPTH))
    else $error("skid buffer occupancy %0d exceeds depth %0d", occ, BUF_DEPTH);

endmodule

// File: rtl/fifo_ddr3_rd_fwft_stage.sv
// FWFT read stage for the DDR3 write-strobe FIFO: credit-gated r_en, RAM latency
// tracking and skid buffering. Define FIFO_DDR3_RD_STATS_EN for stall/starve counters.
module fifo_ddr3_rd_fwft_stage
  import fifo_ddr3_pkg::*;
#(
  parameter int DATA_WIDTH  = $bits(wr_word_t),
  parameter int RAM_LATENCY = 1,
  parameter int CNT_WIDTH   = 3
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  m_count
`ifdef FIFO_DDR3_RD_STATS_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           starve_cnt
`endif
);

  localparam int                   BUF_DEPTH = RAM_LATENCY + 2;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C   = CNT_WIDTH'(BUF_DEPTH);

  logic [RAM_LATENCY-1:0] inflight_r;
  logic [CNT_WIDTH-1:0]   occ_s;
  logic [CNT_WIDTH-1:0]   inflight_s;
  logic [CNT_WIDTH-1:0]   total_s;
  logic                   accept_s;
  logic                   pop_s;

  // Credits come from registered state only, so m_ready never reaches r_en.
  always_comb begin
    inflight_s = {CNT_WIDTH{1'b0}};
    for (int i = 0; i < RAM_LATENCY; i++) begin
      inflight_s = inflight_s + CNT_WIDTH'(inflight_r[i]);
    end
    total_s  = occ_s + inflight_s;
    r_en     = !rempty && (total_s < DEPTH_C);
    accept_s = r_en && !rempty;
    m_valid  = (occ_s != {CNT_WIDTH{1'b0}});
    pop_s    = m_valid && m_ready;
    m_count  = total_s;
  end

  // Valid-bit pipeline mirroring the RAM read latency.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      inflight_r <= {RAM_LATENCY{1'b0}};
    end else begin
      inflight_r[0] <= accept_s;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        inflight_r[i] <= inflight_r[i-1];
      end
    end
  end

  fifo_ddr3_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .BUF_DEPTH (BUF_DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_skid_buf (
    .rclk     (rclk),
    .rrst     (rrst),
    .push     (inflight_r[RAM_LATENCY-1]),
    .push_data(rd_data),
    .pop      (pop_s),
    .occ      (occ_s),
    .head     (m_data)
  );

`ifdef FIFO_DDR3_RD_STATS_EN
  // Saturating stall and starve cycle counters.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      stall_cnt  <= 32'd0;
      starve_cnt <= 32'd0;
    end else begin
      if (m_valid && !m_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (m_ready && !m_valid && (starve_cnt != 32'hFFFF_FFFF)) begin
        starve_cnt <= starve_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
